// File: rtl/alu_exec_stage.sv
// Execute-stage ALU with a registered result behind a valid/ready handshake.
// Define ALU_FAST_SHIFT_EN to make SLL single-cycle (barrel shifter); otherwise SLL shifts 1 bit per cycle.
//
// state | meaning
// IDLE  | no result held, ready for a request
// SHIFT | serial SLL in progress, requests held off
// DONE  | result valid, waiting for out_ready
module alu_exec_stage #(
  parameter int WIDTH   = 32,
  parameter int SHAMT_W = 5
) (
  input  logic               clk,
  input  logic               reset,
  input  logic               in_valid,
  output logic               in_ready,
  input  logic [3:0]         alu_ctr,
  input  logic [WIDTH-1:0]   a,
  input  logic [WIDTH-1:0]   b,
  input  logic [SHAMT_W-1:0] shamt,
  output logic               out_valid,
  input  logic               out_ready,
  output logic [WIDTH-1:0]   result,
  output logic               zero,
  output logic               overflow,
  output logic               busy
);

  localparam logic [3:0] OP_AND  = 4'b0000;
  localparam logic [3:0] OP_OR   = 4'b0001;
  localparam logic [3:0] OP_ADD  = 4'b0010;
  localparam logic [3:0] OP_SUB  = 4'b0110;
  localparam logic [3:0] OP_SLT  = 4'b0111;
  localparam logic [3:0] OP_SLTU = 4'b0101;
  localparam logic [3:0] OP_SLL  = 4'b1000;

  typedef enum logic [1:0] {IDLE, SHIFT, DONE} state_t;

  state_t             state, state_nxt;
  logic               accept, start_shift, shift_last;
  logic [WIDTH-1:0]   sum, diff, op_result, shift_reg, shift_nxt;
  logic               op_ovf;
  logic [SHAMT_W-1:0] cnt;

  assign sum       = a + b;
  assign diff      = a - b;
  assign shift_nxt = shift_reg << 1;

  assign in_ready   = (state == IDLE) || ((state == DONE) && out_ready);
  assign accept     = in_valid && in_ready;
  assign out_valid  = (state == DONE);
  assign shift_last = (cnt == SHAMT_W'(1));

`ifdef ALU_FAST_SHIFT_EN
  assign start_shift = 1'b0;
  assign busy        = 1'b0;
`else
  assign start_shift = (alu_ctr == OP_SLL) && (shamt != '0);
  assign busy        = (state == SHIFT);
`endif

  always_comb begin
    op_result = '0;
    op_ovf    = 1'b0;
    case (alu_ctr)
      OP_AND:  op_result = a & b;
      OP_OR:   op_result = a | b;
      OP_ADD: begin
        op_result = sum;
        op_ovf    = (a[WIDTH-1] == b[WIDTH-1]) && (sum[WIDTH-1] != a[WIDTH-1]);
      end
      OP_SUB: begin
        op_result = diff;
        op_ovf    = (a[WIDTH-1] != b[WIDTH-1]) && (diff[WIDTH-1] != a[WIDTH-1]);
      end
      OP_SLT:  op_result = {{(WIDTH-1){1'b0}}, ($signed(a) < $signed(b))};
      OP_SLTU: op_result = {{(WIDTH-1){1'b0}}, (a < b)};
`ifdef ALU_FAST_SHIFT_EN
      OP_SLL:  op_result = b << shamt;
`else
      // serial path handles shamt != 0; only SLL-by-zero lands here
      OP_SLL:  op_result = b;
`endif
      default: op_result = '0;
    endcase
  end

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE, DONE: begin
        if (accept) state_nxt = start_shift ? SHIFT : DONE;
        else if ((state == DONE) && out_ready) state_nxt = IDLE;
      end
      SHIFT:   if (shift_last) state_nxt = DONE;
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) state <= IDLE;
    else       state <= state_nxt;
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      result    <= '0;
      zero      <= 1'b1;
      overflow  <= 1'b0;
      shift_reg <= '0;
      cnt       <= '0;
    end else if (accept && start_shift) begin
      shift_reg <= b;
      cnt       <= shamt;
    end else if (accept) begin
      result    <= op_result;
      zero      <= (op_result == '0);
      overflow  <= op_ovf;
    end else if (state == SHIFT) begin
      shift_reg <= shift_nxt;
      cnt       <= cnt - SHAMT_W'(1);
      if (shift_last) begin
        result   <= shift_nxt;
        zero     <= (shift_nxt == '0);
        overflow <= 1'b0;
      end
    end
  end

endmodule

// File: tb/tb_alu_exec_stage.sv
// Scoreboard bench for alu_exec_stage: directed corner ops, backpressure, async reset, then random traffic.
// Expected latency and busy counts follow ALU_FAST_SHIFT_EN when it is defined.
module tb_alu_exec_stage;
  localparam int WIDTH   = 32;
  localparam int SHAMT_W = 5;
  localparam longint MAXS = 64'sd2147483647;
  localparam longint MINS = -64'sd2147483648;

  logic               clk = 1'b0;
  logic               reset;
  logic               in_valid, in_ready, out_valid, out_ready;
  logic [3:0]         alu_ctr;
  logic [WIDTH-1:0]   a, b, result;
  logic [SHAMT_W-1:0] shamt;
  logic               zero, overflow, busy;

  alu_exec_stage #(.WIDTH(WIDTH), .SHAMT_W(SHAMT_W)) dut (
    .clk(clk), .reset(reset), .in_valid(in_valid), .in_ready(in_ready),
    .alu_ctr(alu_ctr), .a(a), .b(b), .shamt(shamt),
    .out_valid(out_valid), .out_ready(out_ready), .result(result),
    .zero(zero), .overflow(overflow), .busy(busy)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [31:0] res;
    logic        ovf;
    int          lat;
    int          nbusy;
    int          acc_cyc;
    string       name;
  } exp_t;

  exp_t sb[$];
  int   tests = 0;
  int   fails = 0;
  int   cyc = 0;
  int   bp_mode = 0;
  logic [3:0] opsel [10] = '{4'h0, 4'h1, 4'h2, 4'h6, 4'h7, 4'h5, 4'h8, 4'h3, 4'h4, 4'hF};

  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(string name, logic [63:0] act, logic [63:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // Reference model: ALU semantics from plain integer arithmetic.
  function automatic exp_t model(logic [3:0] op, logic [31:0] x, logic [31:0] y, logic [4:0] sh);
    exp_t   e;
    longint sx, sy, s;
    sx = longint'($signed(x));
    sy = longint'($signed(y));
    e.res = 0; e.ovf = 0; e.lat = 1; e.nbusy = 0; e.acc_cyc = 0; e.name = "";
    case (op)
      4'b0000: e.res = x & y;
      4'b0001: e.res = x | y;
      4'b0010: begin s = sx + sy; e.res = s[31:0]; e.ovf = (s > MAXS) || (s < MINS); end
      4'b0110: begin s = sx - sy; e.res = s[31:0]; e.ovf = (s > MAXS) || (s < MINS); end
      4'b0111: e.res = (sx < sy) ? 32'd1 : 32'd0;
      4'b0101: e.res = (x < y) ? 32'd1 : 32'd0;
      4'b1000: begin
        e.res = (int'(sh) >= WIDTH) ? 32'd0 : (y << sh);
`ifndef ALU_FAST_SHIFT_EN
        e.lat   = int'(sh) + 1;
        e.nbusy = int'(sh);
`endif
      end
      default: e.res = 0;
    endcase
    return e;
  endfunction

  // Called at posedge+1; returns at posedge+1 after the accept edge.
  task automatic issue(logic [3:0] op, logic [31:0] x, logic [31:0] y, logic [4:0] sh, string name);
    exp_t e;
    int   n = 0;
    in_valid = 1'b1; alu_ctr = op; a = x; b = y; shamt = sh;
    do begin
      @(negedge clk);
      n++;
    end while (!in_ready && n < 200);
    if (!in_ready) begin
      tests++; fails++;
      $display("FAIL %s_accept_timeout: got in_ready 0 expected 1", name);
    end else begin
      e = model(op, x, y, sh);
      e.name = name;
      e.acc_cyc = cyc;
      sb.push_back(e);
    end
    @(posedge clk); #1;
    in_valid = 1'b0;
  endtask

  task automatic drain();
    int n = 0;
    while (sb.size() != 0 && n < 2000) begin
      @(posedge clk);
      n++;
    end
    @(posedge clk); #1;
    chk("drain_pending", sb.size(), 0);
  endtask

  // Monitor: latency/busy on first sight of each result, values every valid cycle, pop on handshake.
  initial begin : monitor
    bit seen;
    int busy_cnt;
    seen = 0;
    busy_cnt = 0;
    forever begin
      @(negedge clk);
      if (reset) begin
        seen = 0;
        busy_cnt = 0;
      end else begin
        if (busy) begin
          busy_cnt++;
          chk("in_ready_during_shift", in_ready, 0);
          chk("out_valid_during_shift", out_valid, 0);
        end
        if (out_valid) begin
          if (sb.size() == 0) begin
            tests++; fails++;
            $display("FAIL unexpected_output: got result %0h expected no output", result);
          end else begin
            exp_t e;
            e = sb[0];
            if (!seen) begin
              chk({e.name, "_latency"}, cyc - e.acc_cyc, e.lat);
              chk({e.name, "_busy_cycles"}, busy_cnt, e.nbusy);
              seen = 1;
            end
            chk({e.name, "_result"}, result, e.res);
            chk({e.name, "_zero"}, zero, (e.res == 0));
            chk({e.name, "_overflow"}, overflow, e.ovf);
            if (out_ready) begin
              void'(sb.pop_front());
              seen = 0;
              busy_cnt = 0;
            end
          end
        end
      end
    end
  end

  initial begin : backpressure
    forever begin
      @(posedge clk); #1;
      if (bp_mode == 1) out_ready = ($urandom_range(0, 3) != 0);
    end
  end

  initial begin : watchdog
    #3000000;
    $display("FAIL watchdog: got no finish expected finish");
    $fatal(1, "watchdog expired");
  end

  initial begin : main
    reset = 1'b0; in_valid = 1'b0; out_ready = 1'b1;
    alu_ctr = '0; a = '0; b = '0; shamt = '0;
    #1 reset = 1'b1;
    #1;
    chk("reset_out_valid", out_valid, 0);
    chk("reset_result", result, 0);
    chk("reset_zero", zero, 1);
    chk("reset_overflow", overflow, 0);
    chk("reset_busy", busy, 0);
    repeat (2) @(posedge clk);
    #1 reset = 1'b0;

    issue(4'b0010, 32'h7FFF_FFFF, 32'h1, 5'd0, "add_ovf");
    issue(4'b0110, 32'd5, 32'd5, 5'd0, "sub_zero");
    issue(4'b0111, 32'hFFFF_FFFF, 32'h1, 5'd0, "slt");
    issue(4'b0101, 32'hFFFF_FFFF, 32'h1, 5'd0, "sltu");
    issue(4'b0001, 32'hF0, 32'h0F, 5'd0, "or");
    issue(4'b0110, 32'h8000_0000, 32'h1, 5'd0, "sub_ovf");
    issue(4'b1000, 32'h0, 32'h1, 5'd31, "sll31");
    issue(4'b1000, 32'h0, 32'hABCD, 5'd0, "sll0");
    issue(4'b1111, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 5'd0, "unused");
    drain();

    out_ready = 1'b0;
    issue(4'b0010, 32'd3, 32'd4, 5'd0, "bp_add");
    repeat (5) begin
      @(negedge clk);
      chk("bp_in_ready", in_ready, 0);
      chk("bp_out_valid", out_valid, 1);
    end
    @(posedge clk); #1;
    out_ready = 1'b1;
    issue(4'b0000, 32'hC, 32'hA, 5'd0, "b2b_and");
    drain();

    issue(4'b1000, 32'h0, 32'h1, 5'd7, "sll7_aborted");
    @(posedge clk); #3;
    reset = 1'b1;
    #1;
    chk("midreset_out_valid", out_valid, 0);
    chk("midreset_busy", busy, 0);
    chk("midreset_zero", zero, 1);
    chk("midreset_result", result, 0);
    sb.delete();
    @(posedge clk); #3;
    reset = 1'b0;
    @(posedge clk); #1;
    issue(4'b0010, 32'd10, 32'd20, 5'd0, "post_reset_add");
    drain();

    bp_mode = 1;
    for (int i = 0; i < 150; i++) begin
      logic [3:0]  op;
      logic [31:0] x, y;
      logic [4:0]  sh;
      int          g;
      op = opsel[$urandom_range(0, 9)];
      x  = ($urandom_range(0, 3) == 0) ? 32'h8000_0000 - 32'($urandom_range(0, 2)) : $urandom;
      y  = ($urandom_range(0, 3) == 0) ? 32'($urandom_range(0, 2)) : $urandom;
      sh = 5'($urandom_range(0, 31));
      issue(op, x, y, sh, "rand");
      g = $urandom_range(0, 2);
      if (g > 0) begin
        repeat (g) @(posedge clk);
        #1;
      end
    end
    bp_mode = 0;
    out_ready = 1'b1;
    drain();

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
